fft_stream_sequencer: RTL and testbench
=======================================

Name: fft_stream_sequencer

Overview:
- Sits between the Wishbone FFT slave interface and the FFT butterfly core.
- Consumes the sample stream the interface writes (sample data plus FFT_enable/clear strobes) and forwards it to the core through a small FIFO.
- Collects the core's N result words and writes them into the interface's result RAM through its FFT-side port (ADR_FFT / W_R / sDAT_I).
- Raises the finish flag that the interface returns in the status register.

Parameters:
N, 1024, transform length in samples; must be a power of two, >= 4
Log2N, 10, log2(N); width of the RAM address and of the sample counters
data_wordwidth, 32, sample/result word width
fifo_depth, 4, sample FIFO depth toward the core; power of two, >= 2

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
sample_in  in  data_wordwidth  sample word from the interface (its sDAT_O)
sample_en  in  1  sample strobe from the interface (its FFT_enable)
clear_in  in  1  clear strobe from the interface (its clear_out)
core_data_o  out  data_wordwidth  sample word to the core
core_valid_o  out  1  core_data_o valid
core_ready_i  in  1  core accepts core_data_o
res_data_i  in  data_wordwidth  result word from the core
res_valid_i  in  1  res_data_i valid
res_ready_o  out  1  sequencer accepts res_data_i
ram_dat_o  out  data_wordwidth  result word to the RAM (interface sDAT_I)
ram_adr_o  out  Log2N  RAM write address (interface ADR_FFT)
ram_we_o  out  1  RAM write enable (interface enable_in / W_R)
fft_finish_o  out  1  frame complete (interface FFT_finish_in)
busy_o  out  1  high in LOAD after the first sample, and in UNLOAD
overrun_o  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, FIFO empty, overrun_o 0.
- Sample accept: sample_en=1 and clear_in=0. clear_in=1 (with or without sample_en) is a clear, never a sample.
- Clear (any state): next edge -> state IDLE, counters 0, FIFO flushed, fft_finish_o=0, overrun_o=0, ram_we_o=0. Clear has priority over every other event in the same cycle.
- IDLE:
  - fft_finish_o holds its value.
  - On the first accepted sample: push it, in_cnt=1, fft_finish_o<=0, go to LOAD.
- LOAD:
  - Each accepted sample is pushed and in_cnt increments.
  - FIFO full on accept: sample dropped, in_cnt unchanged, overrun_o<=1.
  - When in_cnt reaches N and the FIFO has drained: go to UNLOAD.
  - Samples accepted in UNLOAD are dropped and set overrun_o.
- FIFO: first-word-fall-through.
  - core_valid_o = not empty. Pop when core_valid_o & core_ready_i.
  - Push and pop in the same cycle while full is legal: the pop frees the slot and nothing is dropped.
- UNLOAD:
  - res_ready_o=1; 0 in every other state, where result beats are ignored.
  - Each res_valid_i beat at cycle t produces, at t+1, registered outputs: ram_we_o=1, ram_dat_o=res_data_i, ram_adr_o=addr(out_cnt).
  - out_cnt increments mod N.
  - After beat N is written: state DONE. fft_finish_o=1 in the cycle after the last ram_we_o pulse.
- DONE:
  - fft_finish_o stays 1 until a clear or a new accepted sample.
  - A new sample starts the next frame exactly as from IDLE (finish drops at the next edge).
- ram_we_o is a single-cycle pulse per result beat; it is never high outside UNLOAD or the cycle after the last beat.
- Counters are Log2N+1 bits wide and wrap only by explicit reset.
- Reset mid-frame: everything abandoned; the partially written RAM is not cleaned.

Optional Feature:
- Macro FFT_SEQ_BITREV_EN.
- Defined: addr(k) = bit-reverse of k over Log2N bits. Use this when the core emits results in bit-reversed order, so the RAM holds natural-order bins.
- Undefined: addr(k) = k.

Test Plan:
- Reset/idle (N=8): assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release -> remains IDLE, busy_o=0.
- Normal frame (N=8, core_ready_i=1):
  - Push samples 1..8 -> core_data_o shows 1..8 in order.
  - Core returns 0xA0..0xA7 -> ram_we_o pulses 8 times at addresses 0..7 (macro off) or 0,4,2,6,1,5,3,7 (macro on).
  - fft_finish_o=1 one cycle after the eighth write.
- Backpressure: core_ready_i=0, push 6 samples, fifo_depth=4 -> samples 5,6 dropped, overrun_o=1, core later receives exactly samples 1..4.
- Clear mid-UNLOAD:
  - After 3 result beats, pulse clear_in with sample_en -> no sample pushed, state IDLE, fft_finish_o=0, overrun_o=0.
  - Remaining result beats are not written.
- Back-to-back frames: in DONE, push a new sample -> fft_finish_o falls next edge, second frame completes with finish=1 again.
- Same-cycle full push/pop: FIFO full, core_ready_i=1 and sample accepted together -> no drop, overrun_o stays 0.

Source files
------------

// File: rtl/fft_stream_sequencer_if.sv
// Core-side streams of the FFT sequencer: samples out, results in.
// master = sequencer, slave = butterfly core.
interface fft_stream_sequencer_if #(
  parameter int data_wordwidth = 32
) ();
  logic [data_wordwidth-1:0] core_data_o;
  logic                      core_valid_o;
  logic                      core_ready_i;
  logic [data_wordwidth-1:0] res_data_i;
  logic                      res_valid_i;
  logic                      res_ready_o;

  modport master (
    output core_data_o,
    output core_valid_o,
    input  core_ready_i,
    input  res_data_i,
    input  res_valid_i,
    output res_ready_o
  );

  modport slave (
    input  core_data_o,
    input  core_valid_o,
    output core_ready_i,
    output res_data_i,
    output res_valid_i,
    input  res_ready_o
  );
endinterface

// File: rtl/fft_stream_sequencer.sv
// Feeds samples to the FFT core via a FWFT FIFO and writes results to RAM.
// Define FFT_SEQ_BITREV_EN to store results at bit-reversed addresses.
module fft_stream_sequencer #(
  parameter int N              = 1024,
  parameter int Log2N          = 10,
  parameter int data_wordwidth = 32,
  parameter int fifo_depth     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [data_wordwidth-1:0] sample_in,
  input  logic                      sample_en,
  input  logic                      clear_in,
  fft_stream_sequencer_if.master    bus,
  output logic [data_wordwidth-1:0] ram_dat_o,
  output logic [Log2N-1:0]          ram_adr_o,
  output logic                      ram_we_o,
  output logic                      fft_finish_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = Log2N + 1;
  localparam logic [CW-1:0] NFULL = CW'(N);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [data_wordwidth-1:0] mem [fifo_depth];
  logic [AW:0]   wr_q, rd_q;
  logic [CW-1:0] in_cnt_q, out_cnt_q;

  logic accept, empty, full;
  logic push, pop, drop, start, beat;

  function automatic logic [Log2N-1:0] addr_of(
    input logic [Log2N-1:0] k
  );
    logic [Log2N-1:0] r;
`ifdef FFT_SEQ_BITREV_EN
    for (int i = 0; i < Log2N; i++)
      r[i] = k[Log2N-1-i];
`else
    r = k;
`endif
    return r;
  endfunction

  assign accept = sample_en & ~clear_in;
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop    = ~empty & bus.core_ready_i;

  assign bus.core_valid_o = ~empty;
  assign bus.core_data_o  = empty ? '0 : mem[rd_q[AW-1:0]];
  assign bus.res_ready_o  = (state_q == UNLOAD);
  assign busy_o = (state_q == LOAD) || (state_q == UNLOAD);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    start   = 1'b0;
    beat    = 1'b0;
    if (clear_in) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        (state_q == IDLE) || (state_q == DONE): begin
          if (accept) begin
            push    = 1'b1;
            start   = 1'b1;
            state_d = LOAD;
          end
        end
        (state_q == LOAD): begin
          // a full FIFO still takes the word if the core pops this cycle
          if (accept) begin
            if ((in_cnt_q < NFULL) && (!full || pop))
              push = 1'b1;
            else
              drop = 1'b1;
          end
          if ((in_cnt_q == NFULL) && empty)
            state_d = UNLOAD;
        end
        (state_q == UNLOAD): begin
          drop = accept;
          if (bus.res_valid_i) begin
            beat = 1'b1;
            if (out_cnt_q == LAST)
              state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q[AW-1:0]] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      ram_we_o     <= 1'b0;
      ram_dat_o    <= '0;
      ram_adr_o    <= '0;
      fft_finish_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (clear_in) begin
      wr_q         <= '0;
      rd_q         <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      ram_we_o     <= 1'b0;
      fft_finish_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      if (start)
        in_cnt_q <= CW'(1);
      else if (push)
        in_cnt_q <= in_cnt_q + 1'b1;
      if (start)
        out_cnt_q <= '0;
      else if (beat)
        out_cnt_q <= (out_cnt_q == LAST) ? '0
                                         : out_cnt_q + 1'b1;
      ram_we_o <= beat;
      if (beat) begin
        ram_dat_o <= bus.res_data_i;
        ram_adr_o <= addr_of(out_cnt_q[Log2N-1:0]);
      end
      if (drop)
        overrun_o <= 1'b1;
      if (start)
        fft_finish_o <= 1'b0;
      else if (state_q == DONE)
        fft_finish_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_stream_sequencer.sv
// Directed bench for fft_stream_sequencer with N=8, fifo_depth=4.
// Honours FFT_SEQ_BITREV_EN for the expected RAM address order.
module tb_fft_stream_sequencer;

  localparam int N  = 8;
  localparam int LN = 3;
  localparam int W  = 32;
  localparam int FD = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  sample_in;
  logic          sample_en;
  logic          clear_in;
  logic [W-1:0]  ram_dat_o;
  logic [LN-1:0] ram_adr_o;
  logic          ram_we_o;
  logic          fft_finish_o;
  logic          busy_o;
  logic          overrun_o;

  fft_stream_sequencer_if #(.data_wordwidth(W)) bus ();

  fft_stream_sequencer #(
    .N(N), .Log2N(LN), .data_wordwidth(W), .fifo_depth(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_in(sample_in),
    .sample_en(sample_en),
    .clear_in(clear_in),
    .bus(bus),
    .ram_dat_o(ram_dat_o),
    .ram_adr_o(ram_adr_o),
    .ram_we_o(ram_we_o),
    .fft_finish_o(fft_finish_o),
    .busy_o(busy_o),
    .overrun_o(overrun_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [LN-1:0] exp_adr [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic test_reset();
    sample_en = 1'b1;
    sample_in = 32'h55;
    tick();
    sample_en = 1'b0;
    n_cmp++;
    if ({busy_o, bus.core_valid_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_busy: got %b want 11",
               {busy_o, bus.core_valid_o});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.core_valid_o, bus.core_data_o, bus.res_ready_o,
         ram_we_o, ram_dat_o, ram_adr_o, fft_finish_o,
         busy_o, overrun_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: outputs not all zero");
    end
    #1 rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy_o, bus.core_valid_o, fft_finish_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b want 000",
               {busy_o, bus.core_valid_o, fft_finish_o});
    end
  endtask

  task automatic test_normal_frame();
    bus.core_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      sample_in = W'(i + 1);
      sample_en = 1'b1;
      tick();
      n_cmp++;
      if ({bus.core_valid_o, bus.core_data_o} !== {1'b1, W'(i + 1)}) begin
        n_bad++;
        $display("FAIL core_data[%0d]: got %h want %h",
                 i, bus.core_data_o, i + 1);
      end
    end
    sample_en = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL load_busy: got %b want 1", busy_o);
    end
    for (int c = 0; c < 20 && !bus.res_ready_o; c++)
      tick();
    n_cmp++;
    if (bus.res_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL unload_entry: got %b want 1", bus.res_ready_o);
    end
    for (int k = 0; k < N; k++) begin
      bus.res_valid_i = 1'b1;
      bus.res_data_i  = W'(32'hA0 + k);
      tick();
      n_cmp++;
      if ({ram_we_o, ram_adr_o, ram_dat_o} !==
          {1'b1, exp_adr[k], W'(32'hA0 + k)}) begin
        n_bad++;
        $display("FAIL ram_write[%0d]: got we=%b adr=%0d dat=%h want we=1 adr=%0d dat=%h",
                 k, ram_we_o, ram_adr_o, ram_dat_o,
                 exp_adr[k], 32'hA0 + k);
      end
    end
    n_cmp++;
    if (fft_finish_o !== 1'b0) begin
      n_bad++;
      $display("FAIL finish_early: got %b want 0", fft_finish_o);
    end
    bus.res_valid_i = 1'b0;
    tick();
    n_cmp++;
    if ({ram_we_o, fft_finish_o, busy_o} !== 3'b010) begin
      n_bad++;
      $display("FAIL frame_done: got we/fin/busy=%b want 010",
               {ram_we_o, fft_finish_o, busy_o});
    end
  endtask

  task automatic test_back_to_back();
    sample_in = 32'h101;
    sample_en = 1'b1;
    tick();
    n_cmp++;
    if ({fft_finish_o, busy_o, bus.core_data_o} !==
        {2'b01, 32'h101}) begin
      n_bad++;
      $display("FAIL b2b_start: got fin=%b busy=%b dat=%h want 0 1 101",
               fft_finish_o, busy_o, bus.core_data_o);
    end
    for (int i = 1; i < N; i++) begin
      sample_in = W'(32'h101 + i);
      tick();
    end
    sample_en = 1'b0;
    for (int c = 0; c < 20 && !bus.res_ready_o; c++)
      tick();
    n_cmp++;
    if (bus.res_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_unload: got %b want 1", bus.res_ready_o);
    end
    for (int k = 0; k < N; k++) begin
      bus.res_valid_i = 1'b1;
      bus.res_data_i  = W'(32'hB0 + k);
      tick();
      n_cmp++;
      if ({ram_we_o, ram_adr_o, ram_dat_o} !==
          {1'b1, exp_adr[k], W'(32'hB0 + k)}) begin
        n_bad++;
        $display("FAIL b2b_write[%0d]: got adr=%0d dat=%h want adr=%0d dat=%h",
                 k, ram_adr_o, ram_dat_o, exp_adr[k], 32'hB0 + k);
      end
    end
    bus.res_valid_i = 1'b0;
    tick();
    n_cmp++;
    if (fft_finish_o !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_finish: got %b want 1", fft_finish_o);
    end
  endtask

  task automatic test_clear_unload();
    logic any_we;
    sample_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      sample_in = W'(32'h200 + i);
      tick();
    end
    sample_en = 1'b0;
    for (int c = 0; c < 20 && !bus.res_ready_o; c++)
      tick();
    for (int k = 0; k < 3; k++) begin
      bus.res_valid_i = 1'b1;
      bus.res_data_i  = W'(32'hC0 + k);
      tick();
    end
    n_cmp++;
    if ({ram_we_o, ram_adr_o, ram_dat_o} !==
        {1'b1, exp_adr[2], 32'hC2}) begin
      n_bad++;
      $display("FAIL clr_beat3: got adr=%0d dat=%h want adr=%0d dat=c2",
               ram_adr_o, ram_dat_o, exp_adr[2]);
    end
    bus.res_valid_i = 1'b0;
    sample_en = 1'b1;
    sample_in = 32'hDEAD;
    tick();
    n_cmp++;
    if ({overrun_o, bus.core_valid_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL unload_drop: got ovr/valid=%b want 10",
               {overrun_o, bus.core_valid_o});
    end
    clear_in = 1'b1;
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = 32'hC3;
    tick();
    clear_in  = 1'b0;
    sample_en = 1'b0;
    n_cmp++;
    if ({busy_o, bus.core_valid_o, fft_finish_o, overrun_o,
         ram_we_o, bus.res_ready_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL clear_state: got %b want 000000",
               {busy_o, bus.core_valid_o, fft_finish_o, overrun_o,
                ram_we_o, bus.res_ready_o});
    end
    any_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.res_data_i = W'(32'hC4 + k);
      tick();
      any_we = any_we | ram_we_o;
    end
    bus.res_valid_i = 1'b0;
    n_cmp++;
    if (any_we !== 1'b0) begin
      n_bad++;
      $display("FAIL write_after_clear: got %b want 0", any_we);
    end
  endtask

  task automatic test_backpressure();
    bus.core_ready_i = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample_in = W'(32'h31 + i);
      tick();
      if (i == 3) begin
        n_cmp++;
        if (overrun_o !== 1'b0) begin
          n_bad++;
          $display("FAIL ovr_at_full: got %b want 0", overrun_o);
        end
      end
    end
    sample_en = 1'b0;
    n_cmp++;
    if ({overrun_o, busy_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL ovr_set: got ovr/busy=%b want 11",
               {overrun_o, busy_o});
    end
    bus.core_ready_i = 1'b1;
    for (int j = 0; j < FD; j++) begin
      n_cmp++;
      if ({bus.core_valid_o, bus.core_data_o} !==
          {1'b1, W'(32'h31 + j)}) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: got v=%b dat=%h want v=1 dat=%h",
                 j, bus.core_valid_o, bus.core_data_o, 32'h31 + j);
      end
      tick();
    end
    n_cmp++;
    if (bus.core_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_extra: got %b want 0", bus.core_valid_o);
    end
    clear_pulse();
    n_cmp++;
    if ({overrun_o, busy_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL ovr_clear: got %b want 00", {overrun_o, busy_o});
    end
  endtask

  task automatic test_same_cycle();
    bus.core_ready_i = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < FD; i++) begin
      sample_in = W'(32'h41 + i);
      tick();
    end
    bus.core_ready_i = 1'b1;
    sample_in = 32'h45;
    tick();
    sample_en = 1'b0;
    n_cmp++;
    if ({overrun_o, bus.core_data_o} !== {1'b0, 32'h42}) begin
      n_bad++;
      $display("FAIL full_push_pop: got ovr=%b dat=%h want 0 42",
               overrun_o, bus.core_data_o);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if ({bus.core_valid_o, bus.core_data_o} !==
          {1'b1, W'(32'h43 + j)}) begin
        n_bad++;
        $display("FAIL pp_drain[%0d]: got dat=%h want %h",
                 j, bus.core_data_o, 32'h43 + j);
      end
    end
    tick();
    n_cmp++;
    if ({bus.core_valid_o, overrun_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL pp_end: got v/ovr=%b want 00",
               {bus.core_valid_o, overrun_o});
    end
    clear_pulse();
  endtask

  initial begin
`ifdef FFT_SEQ_BITREV_EN
    exp_adr = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    exp_adr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    rst_n = 1'b0;
    sample_in = '0;
    sample_en = 1'b0;
    clear_in  = 1'b0;
    bus.core_ready_i = 1'b0;
    bus.res_data_i   = '0;
    bus.res_valid_i  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_normal_frame();
    test_back_to_back();
    test_clear_unload();
    test_backpressure();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
